pll_lock_supervisor: RTL and testbench

- Consumer end of the CCC lock interface. Watches the asynchronous LOCK output of the fabric CCC and re-arms the PLL through its PLL_ARST_N input when lock is lost or never achieved.
- Generates a qualified, glitch-free fabric reset and READY flag for downstream logic.
- Clocked by the free-running reference clock that also feeds CCC CLK0, never by GL0, so it keeps running while the PLL is reset.
- Downstream logic synchronises FABRIC_RST_N into the GL0 domain.

---
 rtl/pll_lock_supervisor_if.sv | 49 ++++
 rtl/pll_lock_supervisor.sv | 190 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if : CCC lock / fabric-reset signal bundle
// Rev 1.0 ; optional glitch_count port under PLL_SUP_GLITCH_FILTER_EN
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if #(
   parameter int CNT_W = 16
);
   logic             lock;
   logic             clr_count;
   logic             pll_arst_n;
   logic             fabric_rst_n;
   logic             ready;
   logic [1:0]       state;
   logic [CNT_W-1:0] loss_count;
   logic [CNT_W-1:0] timeout_count;
`ifdef PLL_SUP_GLITCH_FILTER_EN
   logic [7:0]       glitch_count;
`endif

   modport master (
      input  lock,
      input  clr_count,
      output pll_arst_n,
      output fabric_rst_n,
      output ready,
      output state,
      output loss_count,
      output timeout_count
`ifdef PLL_SUP_GLITCH_FILTER_EN
      , output glitch_count
`endif
   );

   modport slave (
      output lock,
      output clr_count,
      input  pll_arst_n,
      input  fabric_rst_n,
      input  ready,
      input  state,
      input  loss_count,
      input  timeout_count
`ifdef PLL_SUP_GLITCH_FILTER_EN
      , input glitch_count
`endif
   );
endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_lock_supervisor : re-arms the CCC PLL and qualifies fabric reset/ready
// Rev 1.0 ; macro PLL_SUP_GLITCH_FILTER_EN enables the RUN-state lock glitch filter
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
   parameter int SYNC_STAGES      = 2,
   parameter int PLL_RST_CYCLES   = 64,
   parameter int LOCK_TIMEOUT     = 65536,
   parameter int LOCK_HOLD_CYCLES = 1024,
   parameter int CNT_W            = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   pll_lock_supervisor_if.master bus
);

   localparam int c_max_ab  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int c_cyc_max = (c_max_ab > LOCK_HOLD_CYCLES) ? c_max_ab : LOCK_HOLD_CYCLES;
   localparam int c_cyc_w   = (c_cyc_max > 1) ? $clog2(c_cyc_max) : 1;

   localparam logic [c_cyc_w-1:0] c_rst_last  = c_cyc_w'(PLL_RST_CYCLES - 1);
   localparam logic [c_cyc_w-1:0] c_tmo_last  = c_cyc_w'(LOCK_TIMEOUT - 1);
   localparam logic [c_cyc_w-1:0] c_hold_last = c_cyc_w'(LOCK_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_PLL_RESET = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_QUALIFY   = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_lock_s;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [c_cyc_w-1:0]     r_cyc;
   logic [c_cyc_w-1:0]     w_cyc_nxt;
   logic                   w_loss_inc;
   logic                   w_tmo_inc;

   logic                   r_pll_arst_n;
   logic                   r_fabric_rst_n;
   logic                   r_ready;
   logic [CNT_W-1:0]       r_loss_count;
   logic [CNT_W-1:0]       r_timeout_count;

`ifdef PLL_SUP_GLITCH_FILTER_EN
   logic [1:0]             r_low;
   logic [1:0]             w_low_nxt;
   logic                   w_glitch_inc;
   logic [7:0]             r_glitch_count;
`endif

   // LOCK is asynchronous; only the last synchroniser stage is ever used
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.lock};
      end
   end

   assign w_lock_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_state_nxt = r_state;
      w_cyc_nxt   = r_cyc + 1'b1;
      w_loss_inc  = 1'b0;
      w_tmo_inc   = 1'b0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
      w_low_nxt    = 2'd0;
      w_glitch_inc = 1'b0;
`endif
      case (r_state)
         S_PLL_RESET: begin
            if (r_cyc == c_rst_last) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cyc_nxt   = '0;
            end
         end
         S_WAIT_LOCK: begin
            // lock arriving on the timeout cycle takes priority over re-arming
            if (w_lock_s) begin
               w_state_nxt = S_QUALIFY;
               w_cyc_nxt   = '0;
            end else if (r_cyc == c_tmo_last) begin
               w_state_nxt = S_PLL_RESET;
               w_cyc_nxt   = '0;
               w_tmo_inc   = 1'b1;
            end
         end
         S_QUALIFY: begin
            if (!w_lock_s) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cyc_nxt   = '0;
            end else if (r_cyc == c_hold_last) begin
               w_state_nxt = S_RUN;
               w_cyc_nxt   = '0;
            end
         end
         S_RUN: begin
            w_cyc_nxt = '0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
            if (!w_lock_s) begin
               if (r_low == 2'd3) begin
                  w_state_nxt = S_WAIT_LOCK;
                  w_loss_inc  = 1'b1;
               end else begin
                  w_low_nxt = r_low + 2'd1;
               end
            end else if (r_low != 2'd0) begin
               w_glitch_inc = 1'b1;
            end
`else
            if (!w_lock_s) begin
               w_state_nxt = S_WAIT_LOCK;
               w_loss_inc  = 1'b1;
            end
`endif
         end
         default: begin
            w_state_nxt = S_PLL_RESET;
            w_cyc_nxt   = '0;
         end
      endcase
   end

   // outputs decode the next state so they change on the state-entry edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_PLL_RESET;
         r_cyc          <= '0;
         r_pll_arst_n   <= 1'b0;
         r_fabric_rst_n <= 1'b0;
         r_ready        <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cyc          <= w_cyc_nxt;
         r_pll_arst_n   <= (w_state_nxt != S_PLL_RESET);
         r_fabric_rst_n <= (w_state_nxt == S_RUN);
         r_ready        <= (w_state_nxt == S_RUN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_loss_count    <= '0;
         r_timeout_count <= '0;
      end else if (bus.clr_count) begin
         r_loss_count    <= '0;
         r_timeout_count <= '0;
      end else begin
         if (w_loss_inc && (r_loss_count != '1)) begin
            r_loss_count <= r_loss_count + 1'b1;
         end
         if (w_tmo_inc && (r_timeout_count != '1)) begin
            r_timeout_count <= r_timeout_count + 1'b1;
         end
      end
   end

`ifdef PLL_SUP_GLITCH_FILTER_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_low          <= 2'd0;
         r_glitch_count <= 8'd0;
      end else begin
         r_low <= w_low_nxt;
         if (bus.clr_count) begin
            r_glitch_count <= 8'd0;
         end else if (w_glitch_inc && (r_glitch_count != 8'hFF)) begin
            r_glitch_count <= r_glitch_count + 8'd1;
         end
      end
   end

   assign bus.glitch_count = r_glitch_count;
`endif

   assign bus.pll_arst_n    = r_pll_arst_n;
   assign bus.fabric_rst_n  = r_fabric_rst_n;
   assign bus.ready         = r_ready;
   assign bus.state         = r_state;
   assign bus.loss_count    = r_loss_count;
   assign bus.timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor : random LOCK waveforms against a dwell-time reference model
// Rev 1.0 ; honours PLL_SUP_GLITCH_FILTER_EN when defined
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

   localparam int SYNC_STAGES      = 2;
   localparam int PLL_RST_CYCLES   = 4;
   localparam int LOCK_TIMEOUT     = 32;
   localparam int LOCK_HOLD_CYCLES = 8;
   localparam int CNT_W            = 4;
   localparam int c_cnt_max        = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;

   pll_lock_supervisor_if #(.CNT_W(CNT_W)) bus ();

   pll_lock_supervisor #(
      .SYNC_STAGES      (SYNC_STAGES),
      .PLL_RST_CYCLES   (PLL_RST_CYCLES),
      .LOCK_TIMEOUT     (LOCK_TIMEOUT),
      .LOCK_HOLD_CYCLES (LOCK_HOLD_CYCLES),
      .CNT_W            (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // reference model: phase per the documented state codes, dwell = edges spent in phase
   int m_phase, m_dwell, m_low, m_loss, m_tmo, m_glitch;
   bit syncq[$];

   function automatic int sat_add(input int v, input int inc, input int max);
      return (v + inc > max) ? max : v + inc;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_dwell = 0; m_low = 0;
      m_loss = 0; m_tmo = 0; m_glitch = 0;
      syncq.delete();
      for (int i = 0; i < SYNC_STAGES; i++) syncq.push_back(1'b0);
   endtask

   task automatic model_step(input bit l, input bit c);
      bit ls;
      int loss_inc = 0, tmo_inc = 0, gl_inc = 0;
      ls = syncq.pop_front();
      syncq.push_back(l);
      case (m_phase)
         0: begin
            m_dwell++;
            if (m_dwell == PLL_RST_CYCLES) begin m_phase = 1; m_dwell = 0; end
         end
         1: begin
            if (ls) begin m_phase = 2; m_dwell = 0; end
            else begin
               m_dwell++;
               if (m_dwell == LOCK_TIMEOUT) begin m_phase = 0; m_dwell = 0; tmo_inc = 1; end
            end
         end
         2: begin
            if (!ls) begin m_phase = 1; m_dwell = 0; end
            else begin
               m_dwell++;
               if (m_dwell == LOCK_HOLD_CYCLES) begin m_phase = 3; m_dwell = 0; end
            end
         end
         default: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
            if (!ls) begin
               m_low++;
               if (m_low == 4) begin m_phase = 1; m_dwell = 0; m_low = 0; loss_inc = 1; end
            end else begin
               if (m_low > 0) gl_inc = 1;
               m_low = 0;
            end
`else
            if (!ls) begin m_phase = 1; m_dwell = 0; loss_inc = 1; end
`endif
         end
      endcase
      if (c) begin
         m_loss = 0; m_tmo = 0; m_glitch = 0;
      end else begin
         m_loss   = sat_add(m_loss, loss_inc, c_cnt_max);
         m_tmo    = sat_add(m_tmo, tmo_inc, c_cnt_max);
         m_glitch = sat_add(m_glitch, gl_inc, 255);
      end
   endtask

   task automatic compare_all();
      check("state",         32'(bus.state),         32'(m_phase));
      check("pll_arst_n",    32'(bus.pll_arst_n),    32'(m_phase != 0));
      check("fabric_rst_n",  32'(bus.fabric_rst_n),  32'(m_phase == 3));
      check("ready",         32'(bus.ready),         32'(m_phase == 3));
      check("loss_count",    32'(bus.loss_count),    32'(m_loss));
      check("timeout_count", 32'(bus.timeout_count), 32'(m_tmo));
`ifdef PLL_SUP_GLITCH_FILTER_EN
      check("glitch_count",  32'(bus.glitch_count),  32'(m_glitch));
`endif
   endtask

   // called at a negedge: drive, let the edge happen, update model, compare at next negedge
   task automatic cycle(input bit l, input bit c);
      bus.lock      = l;
      bus.clr_count = c;
      @(posedge clk);
      model_step(l, c);
      @(negedge clk);
      compare_all();
   endtask

   task automatic hold(input bit l, input int n, input bit c);
      for (int i = 0; i < n; i++) cycle(l, c);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pll_arst_n"},   32'(bus.pll_arst_n),    32'd0);
      check({tag, "_fabric_rst_n"}, 32'(bus.fabric_rst_n),  32'd0);
      check({tag, "_ready"},        32'(bus.ready),         32'd0);
      check({tag, "_state"},        32'(bus.state),         32'd0);
      check({tag, "_loss"},         32'(bus.loss_count),    32'd0);
      check({tag, "_timeout"},      32'(bus.timeout_count), 32'd0);
   endtask

   task automatic lock_latency_run();
      int n;
      n = 0;
      while (bus.state != 2'd1 && n < 20) begin cycle(1'b0, 1'b0); n++; end
      check("reach_wait_lock", 32'(bus.state), 32'd1);
      n = 0;
      do begin cycle(1'b1, 1'b0); n++; end while (!bus.ready && n < 40);
      check("lock_to_ready", 32'(n - 1), 32'(SYNC_STAGES + LOCK_HOLD_CYCLES));
   endtask

   task automatic random_phase(input int segments);
      int len;
      bit l;
      for (int s = 0; s < segments; s++) begin
         l = bit'($urandom_range(0, 1));
         if (l) len = (($urandom_range(0, 2) == 0) ? 5 : 0) + $urandom_range(9, 30);
         else   len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 6);
         for (int i = 0; i < len; i++) cycle(l, bit'($urandom_range(0, 63) == 0));
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.lock      = 1'b0;
      bus.clr_count = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      lock_latency_run();

      // QUALIFY abort after 5 hold cycles, then a clean relock
      hold(1'b1, 3, 1'b0);
      hold(1'b0, 6, 1'b0);
      hold(1'b1, 5, 1'b0);
      hold(1'b0, 2, 1'b0);
      hold(1'b1, 16, 1'b0);

      hold(1'b0, 4 * (PLL_RST_CYCLES + LOCK_TIMEOUT), 1'b0);
      random_phase(150);

      // drive both counters into saturation, then clear across a loss
      hold(1'b0, 18 * (PLL_RST_CYCLES + LOCK_TIMEOUT), 1'b0);
      for (int k = 0; k < 18; k++) begin
         hold(1'b1, 14, 1'b0);
         hold(1'b0, 6, 1'b0);
      end
      check("loss_saturated", 32'(bus.loss_count), 32'(c_cnt_max));
      hold(1'b1, 14, 1'b0);
      hold(1'b0, 6, 1'b1);
      check("clr_over_loss", 32'(bus.loss_count), 32'd0);

      // asynchronous reset while in RUN
      hold(1'b1, 14, 1'b0);
      #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      lock_latency_run();
      random_phase(60);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
